// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered alu among NUM_REQ requesters
// Holds one response slot; a new request may issue when the slot is empty or draining.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  input  logic [3*NUM_REQ-1:0]   req_opcode_in,
  input  logic [8*NUM_REQ-1:0]   req_operand1_in,
  input  logic [8*NUM_REQ-1:0]   req_operand2_in,
  output logic                   alu_enable_out,
  output logic [2:0]             alu_opcode_out,
  output logic [7:0]             alu_input1_out,
  output logic [7:0]             alu_input2_out,
  input  logic [7:0]             alu_result_in,
  output logic                   resp_valid_out,
  input  logic                   resp_ready_in,
  output logic [ID_W-1:0]        resp_id_out,
  output logic [7:0]             resp_data_out,
  output logic                   resp_error_out,
  output logic [15:0]            grant_count_out
);

  localparam logic [2:0] OP_LAST_LEGAL = 3'd4;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            inflight_valid_q, inflight_valid_d;
  logic [ID_W-1:0] inflight_id_q, inflight_id_d;
  logic            error_q, error_d;
  logic [15:0]     grant_count_q, grant_count_d;

  logic            found;
  logic [ID_W:0]   idx;
  logic [ID_W-1:0] win_id;
  logic [2:0]      win_opcode;
  logic [7:0]      win_op1;
  logic [7:0]      win_op2;
  logic            win_illegal;
  logic            can_issue;
  logic            transfer;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    win_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid_in[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = idx[ID_W-1:0];
      end
    end
  end

  assign win_opcode  = req_opcode_in[3*win_id +: 3];
  assign win_op1     = req_operand1_in[8*win_id +: 8];
  assign win_op2     = req_operand2_in[8*win_id +: 8];
  assign win_illegal = (win_opcode > OP_LAST_LEGAL);

  assign can_issue = !inflight_valid_q || resp_ready_in;
  assign transfer  = found && can_issue && !reset_in;

  assign req_ready_out  = transfer ? (NUM_REQ'(1) << win_id) : '0;
  assign alu_enable_out = transfer && !win_illegal;
  assign alu_opcode_out = alu_enable_out ? win_opcode : 3'd0;
  assign alu_input1_out = alu_enable_out ? win_op1 : 8'd0;
  assign alu_input2_out = alu_enable_out ? win_op2 : 8'd0;

  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    inflight_valid_d = inflight_valid_q;
    inflight_id_d    = inflight_id_q;
    error_d          = error_q;
    grant_count_d    = grant_count_q;
    if (transfer) begin
      rr_ptr_d         = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
      inflight_valid_d = 1'b1;
      inflight_id_d    = win_id;
      error_d          = win_illegal;
      grant_count_d    = grant_count_q + 16'd1;
    end else if (inflight_valid_q && resp_ready_in) begin
      inflight_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      rr_ptr_q         <= '0;
      inflight_valid_q <= 1'b0;
      inflight_id_q    <= '0;
      error_q          <= 1'b0;
      grant_count_q    <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_id_q    <= inflight_id_d;
      error_q          <= error_d;
      grant_count_q    <= grant_count_d;
    end
  end

  // The alu result is only meaningful for legal opcodes; errors report zero.
  assign resp_valid_out  = inflight_valid_q;
  assign resp_id_out     = inflight_id_q;
  assign resp_error_out  = error_q;
  assign resp_data_out   = error_q ? 8'd0 : alu_result_in;
  assign grant_count_out = grant_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed tests for alu_arbiter with a registered reference alu
module tb_alu_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [3*N-1:0]    req_opcode;
  logic [8*N-1:0]    op1;
  logic [8*N-1:0]    op2;
  logic              alu_en;
  logic [2:0]        alu_op;
  logic signed [7:0] alu_a;
  logic signed [7:0] alu_b;
  logic signed [7:0] alu_q;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [7:0]        resp_data;
  logic              resp_err;
  logic [15:0]       gcount;

  int          passed = 0;
  int          total  = 0;
  logic [15:0] exp_count;
  logic [3:0]  exp_ready;

  always #5 clk = ~clk;

  // Opcodes: 0 add, 1 subtract, 2 multiply, 3 and, 4 or; holds when not enabled.
  always_ff @(posedge clk) begin
    if (rst) alu_q <= '0;
    else if (alu_en) begin
      case (alu_op)
        3'd0:    alu_q <= alu_a + alu_b;
        3'd1:    alu_q <= alu_a - alu_b;
        3'd2:    alu_q <= alu_a * alu_b;
        3'd3:    alu_q <= alu_a & alu_b;
        3'd4:    alu_q <= alu_a | alu_b;
        default: alu_q <= alu_q;
      endcase
    end
  end

  alu_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clock_in(clk), .reset_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_opcode_in(req_opcode), .req_operand1_in(op1), .req_operand2_in(op2),
    .alu_enable_out(alu_en), .alu_opcode_out(alu_op),
    .alu_input1_out(alu_a), .alu_input2_out(alu_b), .alu_result_in(alu_q),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready), .resp_id_out(resp_id),
    .resp_data_out(resp_data), .resp_error_out(resp_err), .grant_count_out(gcount)
  );

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]         = 1'b1;
    req_opcode[3*i +: 3] = op;
    op1[8*i +: 8]        = a;
    op2[8*i +: 8]        = b;
  endtask

  task automatic clear_reqs();
    req_valid  = '0;
    req_opcode = '0;
    op1        = '0;
    op2        = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; resp_ready = 1'b1; clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'd1, 8'd1);
    @(negedge clk); #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else passed++;
    total++; if (alu_en !== 1'b0) $display("FAIL reset_alu_en: got %b expected 0", alu_en); else passed++;
    @(negedge clk); rst = 1'b0; clear_reqs(); #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else passed++;
    total++; if (resp_id !== 2'd0) $display("FAIL reset_resp_id: got %0d expected 0", resp_id); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b expected 0", resp_err); else passed++;
    total++; if (resp_data !== 8'd0) $display("FAIL reset_resp_data: got %0h expected 0", resp_data); else passed++;
    total++; if (gcount !== 16'd0) $display("FAIL reset_count: got %0h expected 0", gcount); else passed++;
    exp_count = 16'd0;
  endtask

  task automatic test_idle();
    total++; if (req_ready !== 4'b0000) $display("FAIL idle_ready: got %b expected 0000", req_ready); else passed++;
    total++; if (alu_en !== 1'b0) $display("FAIL idle_alu_en: got %b expected 0", alu_en); else passed++;
    @(negedge clk); #1;
    total++; if (gcount !== exp_count) $display("FAIL idle_count: got %0h expected %0h", gcount, exp_count); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL idle_resp_valid: got %b expected 0", resp_valid); else passed++;
  endtask

  task automatic test_single();
    @(negedge clk); set_req(0, 3'd0, 8'd5, 8'd3); #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready); else passed++;
    total++; if (alu_en !== 1'b1) $display("FAIL single_alu_en: got %b expected 1", alu_en); else passed++;
    total++; if (alu_op !== 3'd0 || alu_a !== 8'sd5 || alu_b !== 8'sd3)
      $display("FAIL single_alu_fields: got op %0d a %0d b %0d expected op 0 a 5 b 3", alu_op, alu_a, alu_b); else passed++;
    @(negedge clk); exp_count++; clear_reqs(); #1;
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) $display("FAIL single_resp: got valid %b id %0d expected valid 1 id 0", resp_valid, resp_id); else passed++;
    total++; if (resp_data !== 8'd8 || resp_err !== 1'b0) $display("FAIL single_data: got %0d err %b expected 8 err 0", resp_data, resp_err); else passed++;
    total++; if (gcount !== exp_count) $display("FAIL single_count: got %0d expected %0d", gcount, exp_count); else passed++;
    @(negedge clk); #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", resp_valid); else passed++;
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; @(negedge clk); rst = 1'b0; exp_count = 16'd0;
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'(10*i + 1), 8'd2);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ready = 4'b0001 << order[k];
      total++; if (req_ready !== exp_ready) $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_ready); else passed++;
      if (k > 0) begin
        total++; if (resp_id !== 2'(order[k-1]) || resp_data !== 8'(10*order[k-1] + 3))
          $display("FAIL rr_resp%0d: got id %0d data %0d expected id %0d data %0d", k, resp_id, resp_data, order[k-1], 10*order[k-1] + 3);
        else passed++;
      end
      @(negedge clk); exp_count++;
    end
    clear_reqs(); #1;
    total++; if (resp_id !== 2'd1 || resp_data !== 8'd13) $display("FAIL rr_last_resp: got id %0d data %0d expected id 1 data 13", resp_id, resp_data); else passed++;
    total++; if (gcount !== 16'd6) $display("FAIL rr_count: got %0d expected 6", gcount); else passed++;
  endtask

  task automatic test_backpressure();
    set_req(1, 3'd1, 8'd10, 8'd4); #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL bp_first_ready: got %b expected 0010", req_ready); else passed++;
    @(negedge clk); exp_count++;
    resp_ready = 1'b0;
    set_req(0, 3'd2, 8'd3, 8'd4);
    set_req(1, 3'd0, 8'd1, 8'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'd6)
        $display("FAIL bp_hold%0d: got valid %b id %0d data %0d expected valid 1 id 1 data 6", c, resp_valid, resp_id, resp_data);
      else passed++;
      total++; if (req_ready !== 4'b0000 || alu_en !== 1'b0)
        $display("FAIL bp_block%0d: got ready %b en %b expected ready 0000 en 0", c, req_ready, alu_en);
      else passed++;
      @(negedge clk);
    end
    resp_ready = 1'b1; #1;
    total++; if (req_ready !== 4'b0001 || alu_en !== 1'b1) $display("FAIL bp_release: got ready %b en %b expected ready 0001 en 1", req_ready, alu_en); else passed++;
    @(negedge clk); exp_count++; clear_reqs(); #1;
    total++; if (resp_id !== 2'd0 || resp_data !== 8'd12) $display("FAIL bp_next_resp: got id %0d data %0d expected id 0 data 12", resp_id, resp_data); else passed++;
    @(negedge clk); #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", resp_valid); else passed++;
  endtask

  task automatic test_illegal();
    set_req(2, 3'd7, 8'd9, 8'd9); #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL ill_ready: got %b expected 0100", req_ready); else passed++;
    total++; if (alu_en !== 1'b0 || alu_a !== 8'sd0) $display("FAIL ill_alu: got en %b a %0d expected en 0 a 0", alu_en, alu_a); else passed++;
    @(negedge clk); exp_count++; clear_reqs(); #1;
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_err !== 1'b1 || resp_data !== 8'd0)
      $display("FAIL ill_resp: got valid %b id %0d err %b data %0d expected valid 1 id 2 err 1 data 0", resp_valid, resp_id, resp_err, resp_data);
    else passed++;
    total++; if (gcount !== exp_count) $display("FAIL ill_count: got %0d expected %0d", gcount, exp_count); else passed++;
    @(negedge clk);
  endtask

  task automatic test_signed_wrap();
    int n;
    set_req(3, 3'd2, 8'h80, 8'hFF); #1;
    total++; if (req_ready !== 4'b1000 || alu_en !== 1'b1) $display("FAIL mul_ready: got ready %b en %b expected ready 1000 en 1", req_ready, alu_en); else passed++;
    @(negedge clk); exp_count++; clear_reqs(); #1;
    total++; if (resp_id !== 2'd3 || resp_data !== 8'h80 || resp_err !== 1'b0)
      $display("FAIL mul_resp: got id %0d data %0h err %b expected id 3 data 80 err 0", resp_id, resp_data, resp_err);
    else passed++;
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'd1, 8'd1);
    n = int'(16'hFFFF - exp_count);
    repeat (n) @(negedge clk);
    #1;
    total++; if (gcount !== 16'hFFFF) $display("FAIL count_max: got %0h expected ffff", gcount); else passed++;
    @(negedge clk); #1;
    total++; if (gcount !== 16'h0000) $display("FAIL count_wrap: got %0h expected 0", gcount); else passed++;
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_req(2, 3'd0, 8'd1, 8'd1);
    @(negedge clk); clear_reqs(); rst = 1'b1; #1;
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) $display("FAIL mid_pre_resp: got valid %b id %0d expected valid 1 id 2", resp_valid, resp_id); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL mid_resp_valid: got %b expected 0", resp_valid); else passed++;
    total++; if (gcount !== 16'd0 || resp_data !== 8'd0) $display("FAIL mid_count_data: got count %0d data %0d expected 0 0", gcount, resp_data); else passed++;
    for (int i = 0; i < N; i++) set_req(i, 3'd4, 8'h0F, 8'hF0);
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL mid_rr_ptr: got %b expected 0001", req_ready); else passed++;
    @(negedge clk); clear_reqs(); #1;
    total++; if (resp_id !== 2'd0 || resp_data !== 8'hFF) $display("FAIL mid_after_resp: got id %0d data %0h expected id 0 data ff", resp_id, resp_data); else passed++;
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b1; clear_reqs(); exp_count = 16'd0;
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_signed_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
